load_store_unit: RTL and testbench

Multicycle load/store sequencer between the processor datapath and the 64-bit data memory. It turns one load or store request from the control state machine into properly sequenced accesses on the doubleword-wide memory port. Sub-doubleword stores are done as read-modify-write. Load results come back lane-extracted and sign- or zero-extended, ready for the register-file write-back mux.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/load_store_unit_if.sv | 33 +++
 rtl/lsu_lane_extract.sv | 29 ++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store sequencer.
//   lsu_state_t : sequencer states (IDLE, RD, CAP, WR, DONE)
//   F3_*        : RISC-V funct3 size/sign encodings for loads and stores
//   lane_mask() : byte-enable mask for an access of a given size at a lane
// Optional build macro affecting users of this package: LSU_MISALIGN_CHECK_EN.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Size comes from funct3[1:0]; the mask is shifted up to the byte lane.
  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] m;
    case (f3[1:0])
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request and memory-port signals of the load/store unit.
//   request : start, is_store, funct3, addr, wdata        (datapath -> LSU)
//   memory  : mem_addr, mem_wdata, mem_wr                 (LSU -> memory)
//             mem_rdata                                   (memory -> LSU)
//   status  : busy, done, rdata, err                      (LSU -> datapath)
// master = environment side (datapath + memory), slave = the LSU.
interface load_store_unit_if #(
  parameter int ADDR_W = 64
);
  logic              start;
  logic              is_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_wr;
  logic [63:0]       mem_rdata;
  logic              busy;
  logic              done;
  logic [63:0]       rdata;
  logic              err;

  modport master (
    output start, is_store, funct3, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, rdata, err
  );

  modport slave (
    input  start, is_store, funct3, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, rdata, err
  );
endinterface

// File: rtl/lsu_lane_extract.sv
// lsu_lane_extract: combinational load lane extraction and extension.
//   i_word   : 64-bit doubleword read from memory
//   i_off    : byte lane (address bits [2:0])
//   i_funct3 : load size/sign encoding
//   o_result : lane shifted down and sign- or zero-extended to 64 bits
module lsu_lane_extract
  import lsu_pkg::*;
(
  input  logic [63:0] i_word,
  input  logic [2:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_result
);
  logic [63:0] w_shift;

  always_comb begin
    w_shift  = i_word >> {i_off, 3'b000};
    o_result = w_shift;
    case (i_funct3)
      F3_B:    o_result = {{56{w_shift[7]}},  w_shift[7:0]};
      F3_H:    o_result = {{48{w_shift[15]}}, w_shift[15:0]};
      F3_W:    o_result = {{32{w_shift[31]}}, w_shift[31:0]};
      F3_BU:   o_result = {56'd0, w_shift[7:0]};
      F3_HU:   o_result = {48'd0, w_shift[15:0]};
      F3_WU:   o_result = {32'd0, w_shift[31:0]};
      default: o_result = w_shift;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multicycle load/store sequencer on a 64-bit memory port.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : load_store_unit_if.slave (request, memory port, status)
// Sub-doubleword stores are read-modify-write; loads are lane-extracted.
// Build macro LSU_MISALIGN_CHECK_EN: when defined, misaligned or illegal
// accesses abort with err=1; otherwise addresses are forced to natural
// alignment, illegal funct3 acts as ld/sd, and err stays 0.
//
// state | meaning
// IDLE  | waiting for start; request fields latched on acceptance
// RD    | doubleword address presented to memory
// CAP   | read data valid: extract load result or merge store bytes
// WR    | mem_wr high for this single cycle
// DONE  | done pulse; err valid
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input logic              CLK,
  input logic              RST,
  load_store_unit_if.slave bus
);
  lsu_state_t        r_state, w_next;
  logic              r_is_store;
  logic [2:0]        r_f3;
  logic [2:0]        r_off;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;
  logic [63:0]       r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_err;

  logic              w_illegal;
  logic              w_misalign;
  logic [2:0]        w_f3_eff;
  logic [2:0]        w_amask;
  logic [2:0]        w_off;
  logic [7:0]        w_bmask;
  logic [63:0]       w_mask64;
  logic [63:0]       w_wshift;
  logic [63:0]       w_merged;
  logic [63:0]       w_ext;

  // Request decode on the incoming (not yet latched) fields.
  always_comb begin
    w_illegal = bus.is_store ? bus.funct3[2] : (bus.funct3 == 3'b111);
`ifdef LSU_MISALIGN_CHECK_EN
    w_f3_eff = bus.funct3;
`else
    w_f3_eff = w_illegal ? F3_D : bus.funct3;
`endif
    case (w_f3_eff[1:0])
      2'd0:    w_amask = 3'b000;
      2'd1:    w_amask = 3'b001;
      2'd2:    w_amask = 3'b011;
      default: w_amask = 3'b111;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    w_misalign = w_illegal || (|(bus.addr[2:0] & w_amask));
    w_off      = bus.addr[2:0];
`else
    w_misalign = 1'b0;
    w_off      = bus.addr[2:0] & ~w_amask;
`endif
  end

  // Store merge: replace only the addressed bytes of the read doubleword.
  always_comb begin
    w_mask64 = '0;
    w_bmask  = lane_mask(r_f3, r_off);
    for (int i = 0; i < 8; i++) w_mask64[i*8 +: 8] = {8{w_bmask[i]}};
    w_wshift = r_wdata << {r_off, 3'b000};
    w_merged = (bus.mem_rdata & ~w_mask64) | (w_wshift & w_mask64);
  end

  lsu_lane_extract u_extract (
    .i_word   (bus.mem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_result (w_ext)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_misalign)                          w_next = S_DONE;
          else if (bus.is_store && w_f3_eff == F3_D) w_next = S_WR;
          else                                     w_next = S_RD;
        end
      end
      S_RD:    w_next = S_CAP;
      S_CAP:   w_next = r_is_store ? S_WR : S_DONE;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_is_store  <= 1'b0;
      r_f3        <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_wdata <= '0;
      r_mem_addr  <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_is_store <= bus.is_store;
            r_f3       <= w_f3_eff;
            r_off      <= w_off;
            r_wdata    <= bus.wdata;
            r_mem_addr <= {bus.addr[ADDR_W-1:3], 3'b000};
            if (w_misalign) r_err <= 1'b1;
            else if (bus.is_store && w_f3_eff == F3_D) r_mem_wdata <= bus.wdata;
          end
        end
        S_CAP: begin
          if (r_is_store) begin
            r_mem_wdata <= w_merged;
          end else begin
            r_rdata <= w_ext;
            r_err   <= 1'b0;
          end
        end
        S_WR:    r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.mem_wr    = (r_state == S_WR);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rdata     = r_rdata;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus randomized operations for
// load_store_unit, checked against a byte-level memory/result model.
module tb_load_store_unit;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic preload = 1'b1;
  always #5 CLK = ~CLK;

  load_store_unit_if bus ();

  load_store_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mem [0:63];
  logic [7:0]  ref_mem [0:511];
  logic [63:0] ref_rdata;

  function automatic logic [63:0] init_word(input int i);
    if (i == 32) return 64'h0123_4567_89AB_CDEF;
    return 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
  endfunction

  // Memory: registered read, one cycle after mem_addr.
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr[8:3]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr[8:3]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, sizes from funct3, plain arithmetic.
  task automatic model_op(input bit st, input bit [2:0] f3, input logic [63:0] a_in,
                          input logic [63:0] wd, output int e_done, output int e_wr,
                          output bit e_err);
    int n;
    bit legal;
    bit mis;
    logic [63:0] a;
    logic [63:0] val;
    legal = st ? (f3 < 3'd4) : (f3 != 3'd7);
    n = 1 << f3[1:0];
    e_err = 0;
    e_wr = 0;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = !legal || ((a_in % 64'(n)) != 0);
    a = a_in;
`else
    mis = 0;
    if (!legal) n = 8;
    a = a_in - (a_in % 64'(n));
`endif
    if (mis) begin
      e_done = 1;
      e_err = 1;
    end else if (st) begin
      for (int i = 0; i < n; i++) ref_mem[int'(a[8:0]) + i] = wd[8*i +: 8];
      e_wr = (n == 8) ? 1 : 3;
      e_done = (n == 8) ? 2 : 4;
    end else begin
      val = 0;
      for (int i = 0; i < n; i++) val = val | (64'(ref_mem[int'(a[8:0]) + i]) << (8 * i));
      if (!f3[2] && n < 8 && val[8*n-1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
      ref_rdata = val;
      e_done = 3;
    end
  endtask

  // Issues one request, pokes an extra start while busy, observes 8 cycles.
  task automatic run_op(input bit st, input bit [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, output int d_cyc, output int d_cnt,
                        output int w_cyc, output int w_cnt, output logic e_seen,
                        output logic b1);
    d_cyc = 0; d_cnt = 0; w_cyc = 0; w_cnt = 0; e_seen = 0; b1 = 0;
    bus.start = 1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(posedge CLK); #1;
    for (int c = 1; c <= 8; c++) begin
      if (bus.done) begin
        d_cnt++;
        if (d_cyc == 0) d_cyc = c;
        e_seen = bus.err;
      end
      if (bus.mem_wr) begin
        w_cnt++;
        w_cyc = c;
      end
      if (c == 1) begin
        b1 = bus.busy;
        bus.start = 1;
        bus.is_store = 1'($urandom_range(1, 0));
        bus.funct3 = 3'($urandom_range(7, 0));
        bus.addr = 64'($urandom_range(511, 0));
        bus.wdata = {$urandom, $urandom};
      end else begin
        bus.start = 0;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic do_op(input bit st, input bit [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input string tag, output int d_cyc,
                       output logic e_seen);
    int e_done, e_wr, d_cnt, w_cyc, w_cnt;
    bit e_err;
    logic b1;
    model_op(st, f3, a, wd, e_done, e_wr, e_err);
    run_op(st, f3, a, wd, d_cyc, d_cnt, w_cyc, w_cnt, e_seen, b1);
    check({tag, " done_cycle"}, 64'(d_cyc), 64'(e_done));
    check({tag, " done_pulses"}, 64'(d_cnt), 64'd1);
    check({tag, " wr_pulses"}, 64'(w_cnt), (e_wr != 0) ? 64'd1 : 64'd0);
    check({tag, " wr_cycle"}, 64'(w_cyc), 64'(e_wr));
    check({tag, " err"}, 64'(e_seen), 64'(e_err));
    check({tag, " rdata"}, bus.rdata, ref_rdata);
    check({tag, " busy_c1"}, 64'(b1), 64'd1);
    check({tag, " idle_after"}, 64'(bus.busy), 64'd0);
  endtask

  typedef struct {
    bit          st;
    bit [2:0]    f3;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    int          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int d_cyc;
    logic e_seen;
    logic [63:0] w;
    int mism;
    bit wr_seen;

    bus.start = 0; bus.is_store = 0; bus.funct3 = 0; bus.addr = 0; bus.wdata = 0;
    ref_rdata = 0;
    for (int i = 0; i < 64; i++) begin
      w = init_word(i);
      for (int j = 0; j < 8; j++) ref_mem[i*8 + j] = w[8*j +: 8];
    end

    tbl[0]  = '{0, 3'd3, 64'h100, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 0};
    tbl[1]  = '{0, 3'd0, 64'h101, 64'h0, 64'hFFFF_FFFF_FFFF_FFCD, 3, 0};
    tbl[2]  = '{0, 3'd4, 64'h101, 64'h0, 64'h0000_0000_0000_00CD, 3, 0};
    tbl[3]  = '{0, 3'd2, 64'h104, 64'h0, 64'h0000_0000_0123_4567, 3, 0};
    tbl[4]  = '{0, 3'd1, 64'h106, 64'h0, 64'h0000_0000_0000_0123, 3, 0};
    tbl[5]  = '{0, 3'd1, 64'h102, 64'h0, 64'hFFFF_FFFF_FFFF_89AB, 3, 0};
    tbl[6]  = '{1, 3'd1, 64'h102, 64'h1111_2222_3333_BEEF, 64'hFFFF_FFFF_FFFF_89AB, 4, 0};
    tbl[7]  = '{0, 3'd3, 64'h100, 64'h0, 64'h0123_4567_BEEF_CDEF, 3, 0};
    tbl[8]  = '{1, 3'd3, 64'h108, 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_BEEF_CDEF, 2, 0};
    tbl[9]  = '{0, 3'd3, 64'h108, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 3, 0};
`ifdef LSU_MISALIGN_CHECK_EN
    tbl[10] = '{0, 3'd2, 64'h106, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1, 1};
`else
    tbl[10] = '{0, 3'd2, 64'h106, 64'h0, 64'h0000_0000_0123_4567, 3, 0};
`endif
    tbl[11] = '{0, 3'd2, 64'h10C, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 3, 0};
    tbl[12] = '{1, 3'd0, 64'h10F, 64'hFFFF_FFFF_FFFF_FF77, 64'hFFFF_FFFF_DEAD_BEEF, 4, 0};
    tbl[13] = '{0, 3'd4, 64'h10F, 64'h0, 64'h0000_0000_0000_0077, 3, 0};

    repeat (3) @(posedge CLK);
    #1;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst rdata", bus.rdata, 64'd0);
    check("rst err", 64'(bus.err), 64'd0);
    check("rst mem_wr", 64'(bus.mem_wr), 64'd0);
    check("rst mem_addr", bus.mem_addr, 64'd0);
    check("rst mem_wdata", bus.mem_wdata, 64'd0);
    RST = 0;
    preload = 0;
    @(posedge CLK); #1;

    for (int k = 0; k < 14; k++) begin
      do_op(tbl[k].st, tbl[k].f3, tbl[k].addr, tbl[k].wd, $sformatf("vec%0d", k), d_cyc, e_seen);
      check($sformatf("vec%0d tbl_done", k), 64'(d_cyc), 64'(tbl[k].exp_done));
      check($sformatf("vec%0d tbl_err", k), 64'(e_seen), 64'(tbl[k].exp_err));
      check($sformatf("vec%0d tbl_rdata", k), bus.rdata, tbl[k].exp_rd);
    end

    for (int k = 0; k < 40; k++) begin
      do_op(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 64'($urandom_range(511, 0)),
            {$urandom, $urandom}, $sformatf("rnd%0d", k), d_cyc, e_seen);
    end

    // Reset in the CAP cycle of an sb: the write must be abandoned.
    wr_seen = 0;
    bus.start = 1; bus.is_store = 1; bus.funct3 = 3'd0; bus.addr = 64'h100; bus.wdata = 64'hAA;
    @(posedge CLK); #1;
    bus.start = 0;
    wr_seen |= bus.mem_wr;
    @(posedge CLK); #1;
    wr_seen |= bus.mem_wr;
    RST = 1;
    @(posedge CLK); #1;
    wr_seen |= bus.mem_wr;
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst done", 64'(bus.done), 64'd0);
    check("midrst rdata", bus.rdata, 64'd0);
    check("midrst err", 64'(bus.err), 64'd0);
    check("midrst mem_addr", bus.mem_addr, 64'd0);
    check("midrst mem_wdata", bus.mem_wdata, 64'd0);
    RST = 0;
    ref_rdata = 0;
    for (int c = 0; c < 5; c++) begin
      wr_seen |= bus.mem_wr;
      @(posedge CLK); #1;
    end
    check("midrst no_write", 64'(wr_seen), 64'd0);
    do_op(0, 3'd3, 64'h100, 64'h0, "post_rst_ld", d_cyc, e_seen);

    mism = 0;
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = ref_mem[i*8 + j];
      if (mem[i] !== w) mism++;
    end
    check("mem_image mismatching_words", 64'(mism), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
